// File: rtl/bbprx_capture_ctrl_pkg.sv
// Shared bbprx capture constants, FSM state type and header word helper.
package bbprx_capture_ctrl_pkg;

  // Header sync word, header length and USB-aligned packet length.
  localparam logic [15:0] HDR_SYNC_WORD = 16'hA5F0;
  localparam int          HDR_LEN       = 4;
  localparam int          PKT_LEN       = 256;

  localparam int HDR_IDX_W = $clog2(HDR_LEN);
  localparam int WCNT_W    = $clog2(PKT_LEN);

  localparam logic [HDR_IDX_W-1:0] HDR_LAST = HDR_IDX_W'(HDR_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PAD     = 3'd4
  } cap_state_e;

  // Header word selected by its position in the header.
  function automatic logic [15:0] hdr_word(input logic [HDR_IDX_W-1:0] idx,
                                           input logic [31:0]          trig_count,
                                           input logic [15:0]          pulse_count);
    logic [15:0] w;
    case (int'(idx))
      0:       w = HDR_SYNC_WORD;
      1:       w = trig_count[15:0];
      2:       w = trig_count[31:16];
      default: w = pulse_count;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bbprx_edge_detect.sv
// Rising-edge detector for an rxclk-synchronous level.
module bbprx_edge_detect (
  input  logic rxclk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember last cycle's level so a 0->1 step can be seen.
  always_ff @(posedge rxclk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/bbprx_capture_ctrl.sv
// Radar pulse capture controller: on an accepted trigger, writes a 4-word
// header, skips cfg_delay samples, captures cfg_nsamp samples and pads the
// packet with zeros to a whole number of 256-word blocks.
//
// Stream semantics: sample_strobe qualifies sample_in on that cycle only and
// there is no back-pressure; out_strobe qualifies out_data on that cycle only,
// and the rx buffer must accept every strobed word.
module bbprx_capture_ctrl
  import bbprx_capture_ctrl_pkg::*;
(
  input  logic        rxclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trigger,
  input  logic        arp,
  input  logic [15:0] sample_in,
  input  logic        sample_strobe,
  input  logic [15:0] cfg_delay,
  input  logic [13:0] cfg_nsamp,
  output logic        out_strobe,
  output logic [15:0] out_data,
  output logic        busy,
  output logic [15:0] missed_count,
  output logic [2:0]  dbg_state
);

  cap_state_e state, state_next;

  logic                 trig_rise, arp_rise;
  logic                 accept, wr_en, skip_dec, cap_dec;
  logic [15:0]          wr_data;
  logic [HDR_IDX_W-1:0] hdr_idx;
  logic [15:0]          delay_left;
  logic [13:0]          nsamp_left;
  logic [WCNT_W-1:0]    wcnt;
  logic [31:0]          trig_count;
  logic [15:0]          arp_count, arp_count_next, hdr_pulses;

  bbprx_edge_detect u_trig_edge (
    .rxclk (rxclk),
    .reset (reset),
    .level (trigger),
    .rise  (trig_rise)
  );

  bbprx_edge_detect u_arp_edge (
    .rxclk (rxclk),
    .reset (reset),
    .level (arp),
    .rise  (arp_rise)
  );

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // FSM state register.
  always_ff @(posedge rxclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state plus the write/count controls for this cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 16'h0000;
    skip_dec   = 1'b0;
    cap_dec    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trig_rise && enable) begin
          accept     = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        wr_en   = 1'b1;
        wr_data = hdr_word(hdr_idx, trig_count, hdr_pulses);
        if (hdr_idx == HDR_LAST) begin
          if (delay_left != '0)      state_next = ST_DELAY;
          else if (nsamp_left != '0) state_next = ST_CAPTURE;
          else                       state_next = ST_PAD;
        end
      end
      ST_DELAY: begin
        if (sample_strobe) begin
          skip_dec = 1'b1;
          if (delay_left == 16'd1)
            state_next = (nsamp_left != '0) ? ST_CAPTURE : ST_PAD;
        end
      end
      ST_CAPTURE: begin
        if (sample_strobe) begin
          wr_en   = 1'b1;
          wr_data = sample_in;
          cap_dec = 1'b1;
          if (nsamp_left == 14'd1) state_next = ST_PAD;
        end
      end
      ST_PAD: begin
        // A zero word count here means the packet is already block-aligned.
        if (wcnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          wr_en = 1'b1;
          if (wcnt == {WCNT_W{1'b1}}) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pulses-since-arp: an accepted trigger on an arp edge restarts at 1.
  always_comb begin
    arp_count_next = arp_count;
    if (accept)        arp_count_next = arp_rise ? 16'd1 : arp_count + 16'd1;
    else if (arp_rise) arp_count_next = '0;
  end

  // Output register, packet counters and trigger statistics.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      out_strobe   <= 1'b0;
      out_data     <= '0;
      hdr_idx      <= '0;
      delay_left   <= '0;
      nsamp_left   <= '0;
      wcnt         <= '0;
      trig_count   <= '0;
      arp_count    <= '0;
      hdr_pulses   <= '0;
      missed_count <= '0;
    end else begin
      out_strobe <= wr_en;
      arp_count  <= arp_count_next;
      if (wr_en) begin
        out_data <= wr_data;
        wcnt     <= wcnt + WCNT_W'(1);
      end
      if (accept) begin
        trig_count <= trig_count + 32'd1;
        delay_left <= cfg_delay;
        nsamp_left <= cfg_nsamp;
        wcnt       <= '0;
        hdr_idx    <= '0;
        hdr_pulses <= arp_count_next;
      end
      if (state == ST_HDR) hdr_idx    <= hdr_idx + HDR_IDX_W'(1);
      if (skip_dec)        delay_left <= delay_left - 16'd1;
      if (cap_dec)         nsamp_left <= nsamp_left - 14'd1;
      if (trig_rise && busy && (missed_count != 16'hFFFF))
        missed_count <= missed_count + 16'd1;
    end
  end

endmodule
